// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store data.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data priority with starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_data;

    // owner / last_grant encoding: 0 = fetch, 1 = data
`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;
`else
    logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

    always_comb begin
        grant_data = 1'b0;
        if (d_req && !if_req) begin
            grant_data = 1'b1;
        end else if (d_req && if_req) begin
`ifdef MEM_ARB_RR_EN
            grant_data = !last_grant_q;
`else
            grant_data = (starve_cnt_q < 4'(STARVE_MAX));
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`else
        starve_cnt_d = starve_cnt_q;
`endif
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d = grant_data;
                    we_d    = grant_data & d_we;
                    addr_d  = grant_data ? d_addr : if_addr;
                    wdata_d = grant_data ? d_wdata : '0;
                    cnt_d   = 4'(MEM_LAT - 1);
                    state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = grant_data;
`else
                    if (grant_data && if_req)
                        starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
                    else
                        starve_cnt_d = 4'd0;
`endif
                end
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        if (owner_q) d_rdata_d  = mem_rdata;
                        else         if_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // Unconditional return to IDLE keeps a still-high req from re-granting here
                if_ack  = !owner_q;
                d_ack   = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= 1'b0;
`else
            starve_cnt_q <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q != IDLE);

endmodule
